identifier_block: RTL and testbench



---
 rtl/can_pkg.sv | 17 +
 rtl/identifier_block_id_assemble.sv | 27 ++
 rtl/identifier_block.sv | 82 ++++++++
 tb/tb_identifier_block.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN identifier types and widths for the frame decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package can_pkg;

  localparam int STD_ID_W = 11;
  localparam int EXT_ID_W = 18;
  localparam int ID_W     = STD_ID_W + EXT_ID_W;

  typedef logic [ID_W-1:0] can_id_t;

  typedef enum logic {
    FMT_STD = 1'b0,
    FMT_EXT = 1'b1
  } frame_fmt_t;

endpackage

// File: rtl/identifier_block_id_assemble.sv
// Builds the 29-bit identifier word from base/extension fields and the frame format.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   idf    - base identifier ID[28:18]
//   idf_ex - extension identifier ID[17:0]
//   fmt    - FMT_STD: word = zero-extended base id; FMT_EXT: word = {idf, idf_ex}
//   word   - assembled identifier
module id_assemble
  import can_pkg::*;
(
  input  logic [STD_ID_W-1:0] idf,
  input  logic [EXT_ID_W-1:0] idf_ex,
  input  frame_fmt_t          fmt,
  output can_id_t             word
);

  always_comb begin
    word = '0;
    case (fmt)
      FMT_EXT: word = {idf, idf_ex};
      default: word = {{EXT_ID_W{1'b0}}, idf};
    endcase
  end

endmodule

// File: rtl/identifier_block.sv
// Identifier assembly stage: latches the CAN identifier into IDTFR on a rising edge of F_IDF.
// Latency: IDTFR updates on the same SP edge that first samples F_IDF high (valid one edge later).
// Backpressure: none; captures are level-to-edge converted, extra high cycles are ignored.
//
// Ports:
//   SP     - sample-point clock, all state on its rising edge
//   reset  - asynchronous active-low reset
//   IDF    - base identifier ID[28:18]
//   IDF_EX - extension identifier ID[17:0]
//   IDE    - 0 = standard frame, 1 = extended frame
//   F_IDF  - identifier-field-complete level flag
//   IDTFR  - registered assembled identifier
//
// Build option: IDENTIFIER_BLOCK_ACC_FILTER_EN enables acceptance filtering of
// captured words against ACC_CODE/ACC_MASK (mask bit 1 = bit must match).
module identifier_block
  import can_pkg::*;
#(
  parameter int             STD_W    = STD_ID_W,
  parameter int             EXT_W    = EXT_ID_W,
  parameter logic [ID_W-1:0] ACC_CODE = '0,
  parameter logic [ID_W-1:0] ACC_MASK = '0
) (
  input  logic                   SP,
  input  logic                   reset,
  input  logic [STD_W-1:0]       IDF,
  input  logic [EXT_W-1:0]       IDF_EX,
  input  logic                   IDE,
  input  logic                   F_IDF,
  output logic [STD_W+EXT_W-1:0] IDTFR
);

  can_id_t    word;
  frame_fmt_t fmt;
  logic       capture;
  logic       accept;

  logic       f_idf_q, f_idf_d;
  can_id_t    idtfr_q, idtfr_d;

  assign fmt = frame_fmt_t'(IDE);

  id_assemble u_id_assemble (
    .idf    (IDF),
    .idf_ex (IDF_EX),
    .fmt    (fmt),
    .word   (word)
  );

  // History is cleared by reset, so F_IDF already high on the first edge
  // after release is treated as a fresh rising edge.
  assign capture = F_IDF & ~f_idf_q;

`ifdef IDENTIFIER_BLOCK_ACC_FILTER_EN
  assign accept = ((word ^ ACC_CODE) & ACC_MASK) == '0;
`else
  assign accept = 1'b1;
  logic unused_acc_params;
  assign unused_acc_params = ^{ACC_CODE, ACC_MASK};
`endif

  always_comb begin
    f_idf_d = F_IDF;
    idtfr_d = idtfr_q;
    if (capture && accept) begin
      idtfr_d = word;
    end
  end

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      f_idf_q <= 1'b0;
      idtfr_q <= '0;
    end else begin
      f_idf_q <= f_idf_d;
      idtfr_q <= idtfr_d;
    end
  end

  assign IDTFR = idtfr_q;

endmodule

// File: tb/tb_identifier_block.sv
// Scoreboard bench for identifier_block: directed scenarios then random traffic.
// Latency: expected IDTFR for each SP edge is queued at stimulus time and popped after the edge.
// Backpressure: n/a.
module tb_identifier_block;

  localparam logic [28:0] TB_CODE = 29'h19280000;
  localparam logic [28:0] TB_MASK = 29'h1FFC0000;

  logic        SP = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] IDF = '0;
  logic [17:0] IDF_EX = '0;
  logic        IDE = 1'b0;
  logic        F_IDF = 1'b0;
  logic [28:0] IDTFR;

  int checks = 0;
  int failures = 0;

  logic [28:0] exp_q[$];

  // Reference model state: identifier currently held and last sampled F_IDF.
  logic [28:0] m_id = '0;
  logic        m_prev = 1'b0;

  identifier_block #(
    .STD_W    (11),
    .EXT_W    (18),
    .ACC_CODE (TB_CODE),
    .ACC_MASK (TB_MASK)
  ) dut (
    .SP     (SP),
    .reset  (reset),
    .IDF    (IDF),
    .IDF_EX (IDF_EX),
    .IDE    (IDE),
    .F_IDF  (F_IDF),
    .IDTFR  (IDTFR)
  );

  always #5 SP = ~SP;

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: IDTFR=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and queue the value IDTFR
  // must show after the following rising edge.
  task automatic drive(input logic rst, input logic f, input logic ide,
                       input logic [10:0] idf, input logic [17:0] idfex);
    logic [28:0] w;
    logic        pass;
    @(negedge SP);
    reset  = rst;
    F_IDF  = f;
    IDE    = ide;
    IDF    = idf;
    IDF_EX = idfex;
    if (!rst) begin
      m_id   = '0;
      m_prev = 1'b0;
    end else begin
      if (f && !m_prev) begin
        w = ide ? (29'(idf) * 29'd262144 + 29'(idfex)) : 29'(idf);
`ifdef IDENTIFIER_BLOCK_ACC_FILTER_EN
        pass = ((w ^ TB_CODE) & TB_MASK) == 29'd0;
`else
        pass = 1'b1;
`endif
        if (pass) m_id = w;
      end
      m_prev = f;
    end
    exp_q.push_back(m_id);
  endtask

  // Monitor: compares every SP edge that has a queued expectation.
  initial begin
    forever begin
      @(posedge SP);
      #1;
      if (exp_q.size() != 0) check("scoreboard", IDTFR, exp_q.pop_front());
    end
  end

  initial begin
    logic [10:0] id_a;
    logic [17:0] ex_a;
    id_a = 11'b11001001010;
    ex_a = 18'b111110001011000000;

    #1;
    check("reset_t0", IDTFR, 29'h0);

    // Reset held with arbitrary traffic.
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 11'($urandom), 18'($urandom));
    @(negedge SP);
    check("reset_hold", IDTFR, 29'h0);

    // Standard capture.
    drive(1'b1, 1'b0, 1'b0, id_a, ex_a);
    drive(1'b1, 1'b1, 1'b0, id_a, ex_a);
    @(negedge SP);
`ifdef IDENTIFIER_BLOCK_ACC_FILTER_EN
    check("std_filtered", IDTFR, 29'h0);
`else
    check("std_capture", IDTFR, 29'h000064A);
`endif

    // Extended capture.
    drive(1'b1, 1'b0, 1'b1, id_a, ex_a);
    drive(1'b1, 1'b1, 1'b1, id_a, ex_a);
    @(negedge SP);
    check("ext_capture", IDTFR, 29'h192BE2C0);

    // Inputs change while F_IDF stays high: ignored.
    drive(1'b1, 1'b1, 1'b0, 11'h7FF, ex_a);
    drive(1'b1, 1'b1, 1'b0, 11'h7FF, ex_a);
    @(negedge SP);
    check("hold_high", IDTFR, 29'h192BE2C0);

    // Drop and re-raise F_IDF.
    drive(1'b1, 1'b0, 1'b0, 11'h7FF, ex_a);
    drive(1'b1, 1'b1, 1'b0, 11'h7FF, ex_a);
    @(negedge SP);
`ifdef IDENTIFIER_BLOCK_ACC_FILTER_EN
    check("recapture_filtered", IDTFR, 29'h192BE2C0);
`else
    check("recapture", IDTFR, 29'h00007FF);
`endif

    // Restore the extended identifier, then reset asynchronously between edges.
    drive(1'b1, 1'b0, 1'b1, id_a, ex_a);
    drive(1'b1, 1'b1, 1'b1, id_a, ex_a);
    @(posedge SP);
    #2;
    check("pre_async", IDTFR, 29'h192BE2C0);
    reset = 1'b0;
    #1;
    check("async_reset", IDTFR, 29'h0);
    reset = 1'b1;
    m_id   = '0;
    m_prev = 1'b0;
    // F_IDF still high on first edge after release: counts as a rising edge.
    drive(1'b1, 1'b1, 1'b1, id_a, ex_a);
    @(negedge SP);
    check("first_edge_after_reset", IDTFR, 29'h192BE2C0);

`ifdef IDENTIFIER_BLOCK_ACC_FILTER_EN
    drive(1'b1, 1'b0, 1'b1, 11'h001, ex_a);
    drive(1'b1, 1'b1, 1'b1, 11'h001, ex_a);
    @(negedge SP);
    check("filter_reject", IDTFR, 29'h192BE2C0);
`endif

    // Random traffic, biased so F_IDF toggles often and reset is rare.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] r_idf;
      r_idf = (($urandom % 4) == 0) ? id_a : 11'($urandom);
      drive(($urandom % 40) != 0, ($urandom % 3) != 0, 1'($urandom),
            r_idf, 18'($urandom));
    end

    repeat (2) @(negedge SP);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
